// File: rtl/lab022_arb_pkg.sv
// Shared types and constants for the AXI4-Lite requester arbiter.
package lab022_arb_pkg;

  localparam int unsigned DefNReq  = 2;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 32;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWresp,
    StRaddr,
    StRdata,
    StDone
  } arb_state_e;

endpackage

// File: rtl/lab022_axil_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the shared slave.
interface lab022_axil_arbiter_if
  import lab022_arb_pkg::*;
#(
  parameter int unsigned C_AXI_ADDR_WIDTH = DefAddrW
);

  logic [C_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DefDataW-1:0]         wdata;
  logic [DefDataW/8-1:0]       wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DefDataW-1:0]         rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/lab022_arb_pick.sv
// Requester selection. Round-robin from ptr_i by default; lowest index wins
// when LAB022_ARB_FIXED_PRIO_EN is defined (ptr_i then ignored).
module lab022_arb_pick
  import lab022_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned IdxW  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  grant_o,
  output logic             valid_o
);

  logic [IdxW-1:0] cand [N_REQ];

  // Candidate order: search sequence of requester indices.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef LAB022_ARB_FIXED_PRIO_EN
      cand[i] = IdxW'(i);
`else
      cand[i] = IdxW'((32'(ptr_i) + i) % N_REQ);
`endif
    end
  end

  // First requesting candidate in search order wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid_o && req_i[cand[i]]) begin
        grant_o = cand[i];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lab022_axil_arbiter.sv
// Arbitrates N_REQ simple requesters onto one AXI4-Lite master port, one
// transaction outstanding. Optional macro: LAB022_ARB_FIXED_PRIO_EN.
module lab022_axil_arbiter
  import lab022_arb_pkg::*;
#(
  parameter int unsigned N_REQ            = DefNReq,
  parameter int unsigned C_AXI_ADDR_WIDTH = DefAddrW,
  parameter int unsigned C_AXI_DATA_WIDTH = DefDataW
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ-1:0]                    we_i,
  input  logic [N_REQ*C_AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ*C_AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]                    done_o,
  output logic [C_AXI_DATA_WIDTH-1:0]         rdata_o,
  output logic [1:0]                          resp_o,
  output logic                                busy_o,
  lab022_axil_arbiter_if.master               m_axi
);

  localparam int unsigned IdxW = (N_REQ > 2) ? 2 : 1;

  arb_state_e                  state_q, state_d;
  logic [IdxW-1:0]             ptr_q, ptr_d, gnt_q, gnt_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        aw_done_q, aw_done_d, w_done_q, w_done_d;
  // Low for the first cycle after reset release so no grant happens there.
  logic                        armed_q;

  logic [C_AXI_ADDR_WIDTH-1:0] addr_arr  [N_REQ];
  logic [C_AXI_DATA_WIDTH-1:0] wdata_arr [N_REQ];
  logic [IdxW-1:0]             pick_idx;
  logic                        pick_valid;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
    assign wdata_arr[g] = wdata_i[g*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
  end

  lab022_arb_pick #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_valid)
  );

  // AXI outputs decode purely from registered state, so they hold while stalled.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state_q == StWaddr) && !aw_done_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state_q == StWaddr) && !w_done_q;
  assign m_axi.bready  = (state_q == StWresp);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_q == StRaddr);
  assign m_axi.rready  = (state_q == StRdata);

  assign busy_o  = (state_q != StIdle);
  assign rdata_o = rdata_q;
  assign resp_o  = resp_q;

  // One-cycle completion strobe for the current grantee.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      done_o[i] = (state_q == StDone) && (gnt_q == IdxW'(i));
    end
  end

  // Next-state: grant, address/data phases, response capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      StIdle: begin
        if (armed_q && pick_valid) begin
          gnt_d     = pick_idx;
          ptr_d     = IdxW'((32'(pick_idx) + 32'd1) % N_REQ);
          addr_d    = addr_arr[pick_idx];
          wdata_d   = wdata_arr[pick_idx];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we_i[pick_idx] ? StWaddr : StRaddr;
        end
      end
      StWaddr: begin
        aw_done_d = aw_done_q || (m_axi.awvalid && m_axi.awready);
        w_done_d  = w_done_q || (m_axi.wvalid && m_axi.wready);
        if (aw_done_d && w_done_d) state_d = StWresp;
      end
      StWresp: begin
        if (m_axi.bvalid) begin
          resp_d  = m_axi.bresp;
          state_d = StDone;
        end
      end
      StRaddr: begin
        if (m_axi.arready) state_d = StRdata;
      end
      StRdata: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          resp_d  = m_axi.rresp;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RespOkay;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      armed_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lab022_axil_arbiter.sv
// Bench for lab022_axil_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model and a configurable-latency AXI slave.
module tb_lab022_axil_arbiter;
  import lab022_arb_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0]    req, we, done;
  logic [3:0]      addr_a  [N];
  logic [31:0]     wdata_a [N];
  logic [N*AW-1:0] addr;
  logic [N*32-1:0] wdata;
  logic [31:0]     rdata;
  logic [1:0]      resp;
  logic            busy;

  assign addr  = {addr_a[1], addr_a[0]};
  assign wdata = {wdata_a[1], wdata_a[0]};

  lab022_axil_arbiter_if #(.C_AXI_ADDR_WIDTH(AW)) axi ();

  lab022_axil_arbiter #(
    .N_REQ            (N),
    .C_AXI_ADDR_WIDTH (AW),
    .C_AXI_DATA_WIDTH (32)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rstn),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .done_o  (done),
    .rdata_o (rdata),
    .resp_o  (resp),
    .busy_o  (busy),
    .m_axi   (axi)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] slv_resp(input logic [3:0] a);
    return (a[1:0] != 2'b00) ? RespSlverr : RespOkay;
  endfunction

  // ---------------- AXI slave with per-channel wait states ----------------
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, b_pend, r_pend;
  logic [3:0]  waddr_l, raddr_l;
  logic [31:0] wdata_l;
  logic [31:0] mem [4];

  wire aw_hs  = axi.awvalid && axi.awready;
  wire w_hs   = axi.wvalid && axi.wready;
  wire ar_hs  = axi.arvalid && axi.arready;
  wire aw_has = aw_got || aw_hs;
  wire w_has  = w_got || w_hs;
  wire [3:0]  wa_eff = aw_hs ? axi.awaddr : waddr_l;
  wire [31:0] wd_eff = w_hs ? axi.wdata : wdata_l;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_lat);
  assign axi.wready  = axi.wvalid && (w_cnt >= w_lat);
  assign axi.arready = axi.arvalid && (ar_cnt >= ar_lat);
  assign axi.bvalid  = b_pend && (b_cnt >= b_lat);
  assign axi.bresp   = slv_resp(waddr_l);
  assign axi.rvalid  = r_pend && (r_cnt >= r_lat);
  assign axi.rdata   = mem[raddr_l[3:2]];
  assign axi.rresp   = slv_resp(raddr_l);

  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; waddr_l <= axi.awaddr; end
      if (w_hs) begin w_got <= 1'b1; wdata_l <= axi.wdata; end
      if (aw_has && w_has) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
        mem[wa_eff[3:2]] <= wd_eff;
      end
      if (b_pend) begin
        if (axi.bvalid && axi.bready) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
      if (ar_hs) begin
        r_pend <= 1'b1; r_cnt <= 0; raddr_l <= axi.araddr;
      end else if (r_pend) begin
        if (axi.rvalid && axi.rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- Values as sampled by the DUT at each edge --------------
  logic [N-1:0]    req_s, we_s;
  logic [N*AW-1:0] addr_s;
  logic [N*32-1:0] wdata_s;
  logic            busy_s, rstn_s, rstn_s2;
  logic            aw_stall_s, w_stall_s, ar_stall_s;
  logic [3:0]      awaddr_s, araddr_s;
  logic [31:0]     wdat_s;

  always @(posedge clk) begin
    req_s      <= req;
    we_s       <= we;
    addr_s     <= addr;
    wdata_s    <= wdata;
    busy_s     <= busy;
    rstn_s     <= rstn;
    rstn_s2    <= rstn_s;
    aw_stall_s <= axi.awvalid && !axi.awready;
    w_stall_s  <= axi.wvalid && !axi.wready;
    ar_stall_s <= axi.arvalid && !axi.arready;
    awaddr_s   <= axi.awaddr;
    araddr_s   <= axi.araddr;
    wdat_s     <= axi.wdata;
  end

  // ---------------- Transaction-level reference model ----------------------
  typedef struct {
    int          g;
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;
  } txn_t;

  txn_t        pend_q[$];
  int          ptr_m;
  logic [31:0] rdata_m;
  logic [1:0]  resp_m;
  logic [31:0] mem_m [4];

  function automatic int pick_model(input logic [N-1:0] r, input int p);
    logic [N-1:0] sh;
    for (int i = 0; i < N; i++) begin
`ifdef LAB022_ARB_FIXED_PRIO_EN
      sh = r >> i;
      if (sh[0]) return i;
`else
      sh = r >> ((p + i) % N);
      if (sh[0]) return (p + i) % N;
`endif
    end
    return -1;
  endfunction

  initial begin
    int g;
    txn_t t;
    logic [N-1:0] oh, sh;
    ptr_m = 0; rdata_m = '0; resp_m = RespOkay;
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    forever begin
      @(negedge clk);
      if (!rstn_s) begin
        ptr_m = 0; pend_q.delete(); rdata_m = '0; resp_m = RespOkay;
        check_eq("rst_busy_done", {busy, done}, 0);
        check_eq("rst_axi_ctl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        check_eq("rst_rdata_resp", {rdata, resp}, 0);
      end else begin
        if (!rstn_s2) check_eq("no_grant_after_rst", busy, 0);
        if (!busy_s && busy) begin
          g = pick_model(req_s, ptr_m);
          check_eq("grant_without_req", g >= 0, 1);
          if (g >= 0) begin
            t.g = g;
            sh = we_s >> g;
            t.we = sh[0];
            t.a = 4'(addr_s >> (AW * g));
            t.d = 32'(wdata_s >> (32 * g));
            t.exp_rs = slv_resp(t.a);
            if (t.we) begin
              mem_m[t.a[3:2]] = t.d;
              t.exp_rd = '0;
            end else begin
              t.exp_rd = mem_m[t.a[3:2]];
            end
            ptr_m = (g + 1) % N;
            pend_q.push_back(t);
          end
        end
        if (done != '0) begin
          if (pend_q.size() == 0) begin
            check_eq("done_spurious", done, 0);
          end else begin
            t = pend_q.pop_front();
            oh = '0;
            oh = N'(1) << t.g;
            check_eq("done_who", done, oh);
            if (!t.we) rdata_m = t.exp_rd;
            resp_m = t.exp_rs;
          end
        end
        check_eq("rdata_o", rdata, rdata_m);
        check_eq("resp_o", resp, resp_m);
        check_eq("prot_strb", {axi.awprot, axi.arprot, axi.wstrb}, {3'b000, 3'b000, 4'hF});
        check_eq("bready_early", axi.bready && (axi.awvalid || axi.wvalid), 0);
        if (aw_stall_s) check_eq("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, awaddr_s});
        if (w_stall_s) check_eq("w_stable", {axi.wvalid, axi.wdata}, {1'b1, wdat_s});
        if (ar_stall_s) check_eq("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, araddr_s});
      end
    end
  end

  // ---------------- Stimulus ----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
  endtask

  task automatic set_req(input logic [IW-1:0] k, input logic w, input logic [3:0] a,
                         input logic [31:0] d);
    req[k] = 1'b1;
    we[k] = w;
    addr_a[k] = a;
    wdata_a[k] = d;
  endtask

  task automatic do_txn(input logic [IW-1:0] k, input logic w, input logic [3:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic [1:0] rs);
    int n;
    logic [N-1:0] oh;
    set_req(k, w, a, d);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done[k] && n < 100);
    oh = '0;
    oh[k] = 1'b1;
    check_eq("txn_done", done, oh);
    rd = rdata;
    rs = resp;
    req[k] = 1'b0;
  endtask

  int          n, cnt, awc, wc, bc;
  int          order [4];
  logic [31:0] rd;
  logic [1:0]  rs;
  logic [IW-1:0] kk;

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=0", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req = '0; we = '0;
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; wdata_a[i] = '0; end
    do_reset();

    // Single write, zero-wait slave: handshakes at cycle 1, done at cycle 3.
    set_req(1'b0, 1'b1, 4'h4, 32'hA5A50001);
    tick();
    check_eq("t1_awwv_cycle1", axi.awvalid && axi.wvalid, 1);
    tick();
    check_eq("t1_no_done_cycle2", done, 0);
    tick();
    check_eq("t1_done_cycle3", done, 2'b01);
    check_eq("t1_resp", resp, RespOkay);
    req[0] = 1'b0;
    tick();

    // Two readers held continuously: strict alternation from index 0.
    do_reset();
    set_req(1'b0, 1'b0, 4'h4, 32'h0);
    set_req(1'b1, 1'b0, 4'h4, 32'h0);
    cnt = 0; n = 0;
    while (cnt < 4 && n < 200) begin
      tick();
      n++;
      if (done[0]) begin order[cnt] = 0; cnt++; end
      else if (done[1]) begin order[cnt] = 1; cnt++; end
    end
    req = '0;
    check_eq("t2_count", cnt, 4);
    for (int i = 0; i < 4; i++) check_eq("t2_order", order[i], i % 2);
    tick();

    // Write with awready delayed by 3 cycles, wready immediate.
    aw_lat = 3;
    set_req(1'b0, 1'b1, 4'h8, 32'h0000_0033);
    awc = 0; wc = 0; bc = 0; n = 0;
    do begin
      tick();
      n++;
      awc += int'(axi.awvalid);
      wc += int'(axi.wvalid);
      bc += int'(axi.bready);
    end while (!done[0] && n < 50);
    check_eq("t3_done", done[0], 1);
    check_eq("t3_awvalid_cycles", awc, 4);
    check_eq("t3_wvalid_cycles", wc, 1);
    check_eq("t3_bready_cycles", bc, 1);
    req[0] = 1'b0;
    aw_lat = 0;
    tick();

    // Requester 1 fills all words, requester 0 reads them back.
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, 1'b1, 4'(4 * i), 32'(i + 1), rd, rs);
      check_eq("t4_wresp", rs, RespOkay);
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, 1'b0, 4'(4 * i), 32'h0, rd, rs);
      check_eq("t4_rdata", rd, 32'(i + 1));
      check_eq("t4_rresp", rs, RespOkay);
    end

    // Reset while waiting for the write response.
    b_lat = 6;
    set_req(1'b0, 1'b1, 4'h0, 32'hDEAD0000);
    n = 0;
    do begin
      tick();
      n++;
    end while (!axi.bready && n < 20);
    check_eq("t5_in_wresp", axi.bready, 1);
    rstn = 1'b0;
    req = '0;
    tick();
    check_eq("t5_rst_ctl", {busy, done, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
                           axi.rready}, 0);
    check_eq("t5_rst_data", {rdata, resp}, 0);
    b_lat = 0;
    rstn = 1'b1;
    do_txn(1'b1, 1'b0, 4'h0, 32'h0, rd, rs);
    check_eq("t5_req1_rdata", rd, 32'hDEAD0000);

`ifdef LAB022_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins every arbitration.
    do_reset();
    set_req(1'b0, 1'b0, 4'h4, 32'h0);
    set_req(1'b1, 1'b0, 4'h8, 32'h0);
    cnt = 0; n = 0;
    while (cnt < 4 && n < 200) begin
      tick();
      n++;
      if (done != '0) begin
        check_eq("t6_fixed_winner", done, 2'b01);
        cnt++;
      end
    end
    req = '0;
    check_eq("t6_count", cnt, 4);
    tick();
    tick();
`endif

    // Randomized traffic with random wait states; the monitor checks each one.
    for (int c = 0; c < 600; c++) begin
      tick();
      if (!busy) begin
        aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2);
        ar_lat = $urandom_range(0, 2); b_lat = $urandom_range(0, 2);
        r_lat = $urandom_range(0, 2);
      end
      for (int i = 0; i < N; i++) begin
        kk = IW'(i);
        if (done[kk] || !req[kk]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(kk, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
          else
            req[kk] = 1'b0;
        end
      end
    end
    n = 0;
    do begin
      tick();
      n++;
      for (int i = 0; i < N; i++) begin
        kk = IW'(i);
        if (done[kk]) req[kk] = 1'b0;
      end
    end while ((req != '0 || busy) && n < 300);
    tick();
    check_eq("drain_idle", {req, busy}, 0);
    check_eq("drain_model_empty", pend_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lab022_axil_arbiter.md
LAB022_AXIL_ARBITER -- requirements
Module: lab022_axil_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 4, byte address width of the shared AXI4-Lite slave.
REQ-003 SHALL have parameter C_AXI_DATA_WIDTH, default 32, data width, fixed at 32.
REQ-004 SHALL have ports: ACLK  in  1  sole clock, rising edge; ARESETN  in  1  synchronous active-low reset.
REQ-005 SHALL have port req_i  in  N_REQ  per-requester transaction request, held until done_o.
REQ-006 SHALL have port we_i  in  N_REQ  per-requester direction, 1 = write, 0 = read.
REQ-007 SHALL have port addr_i  in  N_REQ*C_AXI_ADDR_WIDTH  packed per-requester address.
REQ-008 SHALL have port wdata_i  in  N_REQ*32  packed per-requester write data.
REQ-009 SHALL have ports: done_o  out  N_REQ  one-cycle completion strobe; rdata_o  out  32  read data; resp_o  out  2  AXI response; busy_o  out  1  transaction in flight.
REQ-010 SHALL have AXI4-Lite master ports: m_axi_awaddr/awprot/awvalid out, awready in; wdata/wstrb/wvalid out, wready in.
REQ-011 SHALL have AXI4-Lite master ports: bresp/bvalid in, bready out; araddr/arprot/arvalid out, arready in; rdata/rresp/rvalid in, rready out.

Function
REQ-012 SHALL implement FSM IDLE, WADDR, WRESP, RADDR, RDATA, DONE, one transaction outstanding at a time.
REQ-013 SHALL, in IDLE with any req_i set, grant one requester, register its we/addr/wdata, and enter WADDR (we=1) or RADDR (we=0).
REQ-014 SHALL arbitrate round-robin: search starts at pointer; pointer becomes grantee+1 mod N_REQ on each grant.
REQ-015 SHALL, in WADDR, assert awvalid and wvalid from state entry; each drops after its own handshake; WRESP entered once both handshakes complete, in either order or same cycle.
REQ-016 SHALL, in WRESP, hold bready=1; on bvalid capture bresp into resp_o and enter DONE.
REQ-017 SHALL, in RADDR, assert arvalid until arready; then RDATA with rready=1; on rvalid capture rdata/rresp and enter DONE.
REQ-018 SHALL, in DONE, pulse done_o[grantee] for exactly one cycle, then return to IDLE; rdata_o/resp_o hold until next capture.
REQ-019 SHALL drive awprot/arprot = 3'b000 and wstrb = all ones; AXI outputs stable while valid and not ready.
REQ-020 SHALL ignore req_i deassertion after grant; the granted transaction always completes.
REQ-021 SHALL achieve latency req_i sampled in IDLE to done_o of 3 cycles against a zero-wait slave; busy_o=1 in every state except IDLE.

Reset
REQ-022 SHALL, with ARESETN low at a rising edge, force IDLE, pointer 0, all valid/ready/done_o/busy_o 0, rdata_o 0, resp_o 0, including mid-transaction.
REQ-023 SHALL not grant in the first cycle after ARESETN rises.

Configuration
REQ-024 SHALL, when LAB022_ARB_FIXED_PRIO_EN is defined, replace round-robin with fixed priority (lowest index wins, pointer unused); when undefined, REQ-014 applies.

Structure
REQ-025 SHALL place the state enum, AXI resp constants (OKAY 2'b00, SLVERR 2'b10) and default widths in package lab022_arb_pkg.
REQ-026 SHALL implement the requester selection (round-robin or fixed) in sub-module lab022_arb_pick.

Verification
REQ-027 SHALL cover: req0 write addr 0x4 data 0xA5A50001, zero-wait slave -> awvalid&wvalid cycle 1, done_o[0] cycle 3, resp_o 2'b00.
REQ-028 SHALL cover: req0 and req1 reads asserted together after reset, re-requested on done -> grant order 0,1,0,1.
REQ-029 SHALL cover: write with awready delayed 3 cycles, wready immediate -> wvalid one cycle, awvalid held 4 cycles, bready only after both handshakes.
REQ-030 SHALL cover: req1 writes 1,2,3,4 to 0x0,0x4,0x8,0xC, req0 reads back -> rdata_o 1,2,3,4, all resp_o OKAY.
REQ-031 SHALL cover: ARESETN low during WRESP -> next edge all outputs 0, IDLE; after release req1 alone granted.
REQ-032 SHALL cover, with LAB022_ARB_FIXED_PRIO_EN: req0 and req1 continuously asserted -> req0 granted every transaction.
